// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: instruction-fetch request/response handshake between the sequencer and instruction memory
// Signals: req_valid/req_ready/req_addr carry the fetch request; rsp_valid/rsp_ready/rsp_inst carry the fetched instruction.
// The master modport is the sequencer; the slave modport is the instruction memory.
interface core_seq_ctrl_if #(
   parameter int unsigned XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_inst;
   modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_inst);
   modport slave  (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_inst);
endinterface

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/execute/writeback sequencer for the RV64 integer core
// Ports: clk; rst_n (async, active-low); imem (core_seq_ctrl_if.master) fetch handshake;
//   dec_is_ebreak_i/dec_has_rd_i/dec_is_mem_i decoder flags; lsu_req_o/lsu_done_i memory access;
//   next_pc_i/pc_o program counter; inst_o latched instruction; rf_wen_o register write enable;
//   halted_o core stopped; err_o fetch timeout.
// Optional: define CORE_SEQ_PERF_CNT_EN to add perf_cycle_o and perf_instret_o counters.
module core_seq_ctrl #(
   parameter int unsigned     XLEN          = 64,
   parameter logic [XLEN-1:0] RESET_PC      = 64'h8000_0000,
   parameter int unsigned     FETCH_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   core_seq_ctrl_if.master  imem,
   input  logic             dec_is_ebreak_i,
   input  logic             dec_has_rd_i,
   input  logic             dec_is_mem_i,
   input  logic             lsu_done_i,
   input  logic [XLEN-1:0]  next_pc_i,
   output logic [31:0]      inst_o,
   output logic             lsu_req_o,
   output logic [XLEN-1:0]  pc_o,
   output logic             rf_wen_o,
   output logic             halted_o,
   output logic             err_o
`ifdef CORE_SEQ_PERF_CNT_EN
   ,
   output logic [63:0]      perf_cycle_o,
   output logic [63:0]      perf_instret_o
`endif
);
   typedef enum logic [2:0] {BOOT, FETCH_REQ, FETCH_WAIT, EXEC, MEM_WAIT, WB, HALT} state_t;
   localparam logic [31:0] NOP = 32'h0000_0013;
   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic            req_valid_q, rsp_ready_q, lsu_req_q, rf_wen_q, halted_q, err_q;
   logic [15:0]     cnt_q, cnt_d;
`ifdef CORE_SEQ_PERF_CNT_EN
   logic [63:0]     perf_cycle_q, perf_instret_q;
   assign perf_cycle_o   = perf_cycle_q;
   assign perf_instret_o = perf_instret_q;
`endif
   assign cnt_d          = cnt_q + 16'd1;
   assign imem.req_valid = req_valid_q;
   assign imem.req_addr  = pc_q;
   assign imem.rsp_ready = rsp_ready_q;
   assign inst_o         = inst_q;
   assign pc_o           = pc_q;
   assign lsu_req_o      = lsu_req_q;
   assign rf_wen_o       = rf_wen_q;
   assign halted_o       = halted_q;
   assign err_o          = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         inst_q      <= NOP;
         req_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         lsu_req_q   <= 1'b0;
         rf_wen_q    <= 1'b0;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
`ifdef CORE_SEQ_PERF_CNT_EN
         perf_cycle_q   <= '0;
         perf_instret_q <= '0;
`endif
      end else begin
         lsu_req_q <= 1'b0;
         rf_wen_q  <= 1'b0;
`ifdef CORE_SEQ_PERF_CNT_EN
         if (state_q != HALT) perf_cycle_q <= perf_cycle_q + 64'd1;
         if (state_q == WB) perf_instret_q <= perf_instret_q + 64'd1;
`endif
         case (state_q)
            BOOT: begin
               state_q     <= FETCH_REQ;
               req_valid_q <= 1'b1;
            end
            FETCH_REQ: if (imem.req_ready) begin
               state_q     <= FETCH_WAIT;
               req_valid_q <= 1'b0;
               rsp_ready_q <= 1'b1;
               cnt_q       <= '0;
            end
            FETCH_WAIT: begin
               // a response on the final allowed cycle wins over the timeout
               if (imem.rsp_valid) begin
                  inst_q      <= imem.rsp_inst;
                  rsp_ready_q <= 1'b0;
                  state_q     <= EXEC;
               end else if (cnt_d == 16'(FETCH_TIMEOUT)) begin
                  err_q       <= 1'b1;
                  halted_q    <= 1'b1;
                  rsp_ready_q <= 1'b0;
                  state_q     <= HALT;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            EXEC: begin
               if (dec_is_ebreak_i) begin
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else if (dec_is_mem_i) begin
                  lsu_req_q <= 1'b1;
                  state_q   <= MEM_WAIT;
               end else begin
                  rf_wen_q <= dec_has_rd_i;
                  state_q  <= WB;
               end
            end
            // lsu_done seen alongside the request pulse belongs to no access of ours
            MEM_WAIT: if (lsu_done_i && !lsu_req_q) begin
               rf_wen_q <= dec_has_rd_i;
               state_q  <= WB;
            end
            WB: begin
               pc_q        <= next_pc_i;
               req_valid_q <= 1'b1;
               state_q     <= FETCH_REQ;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64 integer core: drives the instruction-fetch handshake, holds the fetched instruction stable for decoder/ALU/register file, and gates the PC update and register-file write enable.
- Replaces the free-running PC advance and the hard-wired register write enable of the single-cycle top.
- Sits between the instruction memory port and the decoder/RegisterFile/PC datapath.

Parameters:
- XLEN, 64, width of PC and next-PC.
- RESET_PC, 64'h8000_0000, PC value loaded at reset.
- FETCH_TIMEOUT, 255, maximum cycles in FETCH_WAIT before error halt; valid range 1..65535.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low: rst=0 resets immediately, regardless of clk.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_req_addr  out  XLEN  fetch address; equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_inst  in  32  fetched instruction.
- imem_rsp_ready  out  1  controller accepts response.
- inst  out  32  latched instruction to decoder.
- dec_is_ebreak  in  1  decoder flags ebreak.
- dec_has_rd  in  1  decoder: instruction writes rd.
- lsu_req  out  1  one-cycle pulse: start memory access.
- dec_is_mem  in  1  decoder: load/store.
- lsu_done  in  1  memory access completed.
- next_pc  in  XLEN  PC computed by the execute path.
- pc  out  XLEN  current PC.
- rf_wen  out  1  register-file write enable, one cycle.
- halted  out  1  core stopped.
- err  out  1  fetch timeout occurred.

Behaviour:
- Reset (rst=0): state=BOOT, pc=RESET_PC, inst=32'h0000_0013 (nop), all handshake outputs 0, rf_wen=0, lsu_req=0, halted=0, err=0, timeout counter=0.
- States and transitions:
  - BOOT: one cycle, then FETCH_REQ.
  - FETCH_REQ: imem_req_valid=1. On imem_req_ready=1, go to FETCH_WAIT and clear the timeout counter.
  - FETCH_WAIT: imem_rsp_ready=1.
    - On imem_rsp_valid=1: latch inst<=imem_rsp_inst, go to EXEC.
    - Else the counter increments. When the counter reaches FETCH_TIMEOUT without a response: err<=1, go to HALT.
    - A response arriving on the same cycle the counter reaches FETCH_TIMEOUT is accepted; no error.
  - EXEC: decoder/ALU evaluate the latched inst (one cycle).
    - dec_is_ebreak=1: go to HALT; no rf_wen, pc unchanged.
    - dec_is_mem=1: pulse lsu_req, go to MEM_WAIT.
    - Otherwise: go to WB.
  - MEM_WAIT: wait for lsu_done=1, then go to WB. lsu_done asserted in the same cycle as the lsu_req pulse is ignored. There is no timeout.
  - WB: rf_wen=dec_has_rd, pc<=next_pc, go to FETCH_REQ.
  - HALT: absorbing; halted=1. All request outputs 0 and pc frozen until reset.
- Handshake rules:
  - imem_req_valid, once asserted, stays high and imem_req_addr stays stable until accepted.
  - imem_rsp_ready is high only in FETCH_WAIT.
  - A response is never accepted in the same cycle the request is accepted; minimum fetch latency is 2 cycles.
- CPI: non-memory instruction = 4 cycles with zero-wait memory (FETCH_REQ, FETCH_WAIT, EXEC, WB).
- rf_wen is registered-state decoded: high only in WB, never in EXEC, MEM_WAIT or HALT. This ensures exactly one register write per retired instruction.
- pc updates only in WB. next_pc is taken verbatim, with no alignment check.
- Reset mid-operation: any state returns to BOOT immediately. An in-flight fetch is abandoned. A response arriving in BOOT is ignored, because imem_rsp_ready=0.

Optional Feature:
- Macro: CORE_SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_cycle (64) and perf_instret (64), both reset to 0.
  - perf_cycle increments every cycle while not halted.
  - perf_instret increments once per WB cycle.
  - Both wrap modulo 2^64 and freeze in HALT.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset sequencing: release rst with zero-wait memory returning 32'h00100093 (addi x1,x0,1), next_pc=pc+4 -> imem_req_addr=0x8000_0000 on the first request; rf_wen pulses in WB on cycle 4 after BOOT; pc=0x8000_0004 on the next FETCH_REQ.
- Backpressure: hold imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 and the address stays stable; a single request is accepted on the 6th cycle.
- Timeout: FETCH_TIMEOUT=8, never assert imem_rsp_valid -> err=1 and halted=1 after 8 FETCH_WAIT cycles; pc frozen. Repeat with the response on cycle 8 -> accepted, err=0.
- Load: dec_is_mem=1, lsu_done delayed 3 cycles -> one lsu_req pulse; rf_wen only after lsu_done; instruction takes 7 cycles.
- Ebreak: dec_is_ebreak=1 -> no rf_wen, halted=1 from the next cycle, no further imem_req_valid. With CORE_SEQ_PERF_CNT_EN, perf_instret equals the retired count and is frozen.
- Async reset: drop rst mid-FETCH_WAIT between clock edges -> outputs return to reset values immediately; pc=RESET_PC.
